// File: rtl/delay_meas_pkg.sv
// Shared types and defaults for the start/stop delay measurement controller.
package delay_meas_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_TICK_DIV = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchroniser for an asynchronous pin followed by a rising-edge detector.
module sync_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = pin;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // One pulse per low-to-high transition of the synchronised pin.
    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/delay_meas_ctrl.sv
// Start/stop delay timer sequencer: drives an external counter and captures the elapsed ticks.
module delay_meas_ctrl
    import delay_meas_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             start_in,
    input  logic             stop_in,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             cnt_en,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int             PW        = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic start_rise, stop_rise;

    sync_rise_det u_start_det (.clk(clk), .rst(rst), .pin(start_in), .rise(start_rise));
    sync_rise_det u_stop_det  (.clk(clk), .rst(rst), .pin(stop_in),  .rise(stop_rise));

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             tick;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        result_d = result_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        tick     = (presc_q == TICK_LAST);

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        cnt_load = 1'b1;
                        result_d = '0;
                        valid_d  = 1'b0;
                        ovf_d    = 1'b0;
                        state_d  = ARMED;
                    end
                end
                ARMED: begin
                    if (start_rise && stop_rise) begin
                        result_d = '0;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else if (start_rise) begin
                        // The start cycle itself is prescaler slot 0.
                        state_d = COUNT;
                        if (TICK_LAST == '0) begin
                            cnt_en  = 1'b1;
                            presc_d = '0;
                        end else begin
                            presc_d = PW'(1);
                        end
                    end
                end
                COUNT: begin
                    if (stop_rise) begin
                        result_d = cnt_value;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else if (tick) begin
                        presc_d = '0;
                        if (cnt_value == ALL_ONES) begin
                            ovf_d    = 1'b1;
                            result_d = ALL_ONES;
                            valid_d  = 1'b1;
                            state_d  = DONE;
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (rst) begin
            cnt_load = 1'b0;
            cnt_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cnt_load_val = '0;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overflow     = ovf_q;
    assign busy         = (state_q == ARMED) || (state_q == COUNT);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_delay_meas_ctrl.sv
// Directed bench: two controllers (TICK_DIV 1 and 4) share the pins, each with its own counter.
module tb_delay_meas_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, arm, abort, start_in, stop_in;

    logic [7:0] cnt1, ld_val1, res1;
    logic       load1, en1, rv1, ovf1, busy1;
    logic [1:0] st1;
    logic [7:0] cnt4, ld_val4, res4;
    logic       load4, en4, rv4, ovf4, busy4;
    logic [1:0] st4;

    delay_meas_ctrl #(.WIDTH(8), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .start_in(start_in), .stop_in(stop_in),
        .cnt_value(cnt1), .cnt_load(load1), .cnt_load_val(ld_val1), .cnt_en(en1),
        .result(res1), .result_valid(rv1), .overflow(ovf1), .busy(busy1), .dbg_state(st1)
    );

    delay_meas_ctrl #(.WIDTH(8), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .start_in(start_in), .stop_in(stop_in),
        .cnt_value(cnt4), .cnt_load(load4), .cnt_load_val(ld_val4), .cnt_en(en4),
        .result(res4), .result_valid(rv4), .overflow(ovf4), .busy(busy4), .dbg_state(st4)
    );

    // External counter models
    always_ff @(posedge clk) begin
        if (rst) cnt1 <= 8'd0;
        else if (load1) cnt1 <= ld_val1;
        else if (en1) cnt1 <= cnt1 + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt4 <= 8'd0;
        else if (load4) cnt4 <= ld_val4;
        else if (en4) cnt4 <= cnt4 + 8'd1;
    end

    // Spacing between successive cnt_en pulses of the divide-by-4 instance
    int gap4, gap_err;
    logic seen4;
    always_ff @(posedge clk) begin
        if (rst || load4) begin
            gap4  <= 0;
            seen4 <= 1'b0;
        end else if (en4) begin
            if (seen4 && gap4 != 3) gap_err <= gap_err + 1;
            gap4  <= 0;
            seen4 <= 1'b1;
        end else begin
            gap4 <= gap4 + 1;
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_arm(input string tag);
        arm = 1'b1;
        #1;
        check_eq({tag, "_load1"}, 32'(load1), 32'd1);
        check_eq({tag, "_load4"}, 32'(load4), 32'd1);
        @(negedge clk);
        arm = 1'b0;
        check_eq({tag, "_rv_clr"}, 32'(rv1), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (rv1 && rv4) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, "_done"}, 32'(ok), 32'd1);
    endtask

    task automatic release_pins();
        start_in = 1'b0;
        stop_in  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic measure(input string tag, input int n, input int exp1, input int exp4);
        do_arm(tag);
        start_in = 1'b1;
        repeat (n) @(negedge clk);
        stop_in = 1'b1;
        wait_done(tag, 30);
        check_eq({tag, "_res1"}, 32'(res1), 32'(exp1));
        check_eq({tag, "_res4"}, 32'(res4), 32'(exp4));
        check_eq({tag, "_ovf1"}, 32'(ovf1), 32'd0);
        check_eq({tag, "_ovf4"}, 32'(ovf4), 32'd0);
        check_eq({tag, "_st1"},  32'(st1),  32'd3);
        check_eq({tag, "_cnt4"}, 32'(cnt4), 32'(exp4));
        release_pins();
    endtask

    initial begin
        gap_err  = 0;
        rst      = 1'b1;
        arm      = 1'b0;
        abort    = 1'b0;
        start_in = 1'b0;
        stop_in  = 1'b0;

        // Reset with pins toggling and arm asserted
        @(negedge clk);
        start_in = 1'b1;
        arm      = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        stop_in  = 1'b1;
        #1;
        check_eq("rst_load",  32'(load1), 32'd0);
        check_eq("rst_en",    32'(en1),   32'd0);
        check_eq("rst_st",    32'(st1),   32'd0);
        check_eq("rst_res",   32'(res1),  32'd0);
        check_eq("rst_rv",    32'(rv1),   32'd0);
        check_eq("rst_ovf",   32'(ovf1),  32'd0);
        check_eq("rst_busy",  32'(busy1), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        arm     = 1'b0;
        stop_in = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("post_rst_st", 32'(st4), 32'd0);

        // N clk between start and stop: div1 -> N, div4 -> floor(N/4)
        measure("m10", 10, 10, 2);
        measure("m37", 37, 37, 9);
        check_eq("gap37", 32'(gap_err), 32'd0);

        // Start and stop together in ARMED
        do_arm("sim");
        start_in = 1'b1;
        stop_in  = 1'b1;
        wait_done("sim", 30);
        check_eq("sim_res1", 32'(res1), 32'd0);
        check_eq("sim_res4", 32'(res4), 32'd0);
        check_eq("sim_st4",  32'(st4),  32'd3);
        release_pins();

        // Start alone, then abort while counting
        do_arm("abt");
        start_in = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("abt_st1",   32'(st1),   32'd2);
        check_eq("abt_busy1", 32'(busy1), 32'd1);
        abort = 1'b1;
        #1;
        check_eq("abt_en1", 32'(en1), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        check_eq("abt_idle1", 32'(st1),   32'd0);
        check_eq("abt_idle4", 32'(st4),   32'd0);
        check_eq("abt_busy",  32'(busy1), 32'd0);
        check_eq("abt_rv",    32'(rv1),   32'd0);
        release_pins();

        // arm during COUNT is ignored; stop 20 clk after start
        do_arm("ac");
        start_in = 1'b1;
        repeat (6) @(negedge clk);
        arm = 1'b1;
        #1;
        check_eq("ac_noload1", 32'(load1), 32'd0);
        check_eq("ac_noload4", 32'(load4), 32'd0);
        @(negedge clk);
        arm = 1'b0;
        repeat (13) @(negedge clk);
        stop_in = 1'b1;
        wait_done("ac", 30);
        check_eq("ac_res1", 32'(res1), 32'd20);
        check_eq("ac_res4", 32'(res4), 32'd5);

        // Re-arm from DONE
        arm = 1'b1;
        #1;
        check_eq("rearm_load", 32'(load1), 32'd1);
        @(negedge clk);
        arm = 1'b0;
        check_eq("rearm_rv",  32'(rv1),  32'd0);
        check_eq("rearm_res", 32'(res1), 32'd0);
        check_eq("rearm_st",  32'(st1),  32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        release_pins();

        // Overflow: start, never stop
        do_arm("ovf");
        start_in = 1'b1;
        wait_done("ovf", 1200);
        check_eq("ovf_flag1", 32'(ovf1), 32'd1);
        check_eq("ovf_res1",  32'(res1), 32'hFF);
        check_eq("ovf_st1",   32'(st1),  32'd3);
        check_eq("ovf_cnt1",  32'(cnt1), 32'd255);
        check_eq("ovf_flag4", 32'(ovf4), 32'd1);
        check_eq("ovf_res4",  32'(res4), 32'hFF);
        check_eq("ovf_cnt4",  32'(cnt4), 32'd255);
        check_eq("ovf_gap",   32'(gap_err), 32'd0);
        check_eq("ovf_busy",  32'(busy1), 32'd0);
        release_pins();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
